// File: rtl/data_mem_pkg.sv
// Shared types and the power-on init pattern for the data memory slice.
package data_mem_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned AddrWidth = 8;
    localparam int unsigned MaxDw     = 64;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } state_e;

    // Widest supported word; callers truncate to their own data width.
    function automatic logic [MaxDw-1:0] init_word(input logic             addr_lsb,
                                                   input logic [MaxDw-1:0] even_val,
                                                   input logic [MaxDw-1:0] odd_val);
        return addr_lsb ? odd_val : even_val;
    endfunction

endpackage

// File: rtl/data_mem_seq_array.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
module mem_array_1p #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_seq.sv
// Registered-output data memory with init sweep, valid/ready requests and
// range checking; returns memory data or the ALU result per request.
module data_mem_seq
    import data_mem_pkg::*;
#(
    parameter int unsigned    DW         = DataWidth,
    parameter int unsigned    AW         = AddrWidth,
    parameter int unsigned    DEPTH      = 256,
    parameter int unsigned    INIT_COUNT = 30,
    parameter logic [DW-1:0]  INIT_EVEN  = 8'h55,
    parameter logic [DW-1:0]  INIT_ODD   = 8'h05
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          WriteEn,
    input  logic          MemToReg,
    input  logic [DW-1:0] ALUdata,
    input  logic [AW-1:0] DataAddress,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          RspValid,
    output logic          AddrErr,
    output logic          InitDone
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_we;

    logic          accept, addr_ok, wr_acc;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata, mem_rdata, init_val;

    logic          rsp_valid_d, addr_err_d;
    logic [DW-1:0] data_d;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(INIT_COUNT - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: ;
            default: state_d = INIT;
        endcase
    end

    // Output logic
    always_comb begin
        ReqReady = 1'b0;
        InitDone = 1'b0;
        init_we  = 1'b0;
        unique case (state_q)
            INIT: init_we = 1'b1;
            RUN: begin
                ReqReady = 1'b1;
                InitDone = 1'b1;
            end
            default: ;
        endcase
    end

    assign init_val = DW'(init_word(cnt_q[0], MaxDw'(INIT_EVEN), MaxDw'(INIT_ODD)));

    // DEPTH may be 2**AW, so compare with one extra bit.
    assign addr_ok = ({1'b0, DataAddress} < (AW + 1)'(DEPTH));
    assign accept  = ReqValid & ReqReady;
    assign wr_acc  = accept & WriteEn & addr_ok;

    // Nothing is written in a Reset cycle, including a presented request.
    assign mem_we    = ~Reset & (init_we | wr_acc);
    assign mem_waddr = init_we ? cnt_q[IW-1:0] : DataAddress[IW-1:0];
    assign mem_wdata = init_we ? init_val : DataIn;

    mem_array_1p #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .Clk   (Clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (DataAddress[IW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        rsp_valid_d = accept & ~WriteEn;
        addr_err_d  = accept & ~addr_ok & (WriteEn | MemToReg);
        data_d      = DataOut;
        if (rsp_valid_d) begin
            if (!MemToReg) begin
                data_d = ALUdata;
            end else if (addr_ok) begin
                data_d = mem_rdata;
            end else begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RspValid <= 1'b0;
            AddrErr  <= 1'b0;
            DataOut  <= '0;
        end else begin
            RspValid <= rsp_valid_d;
            AddrErr  <= addr_err_d;
            DataOut  <= data_d;
        end
    end

endmodule

// File: doc/data_mem_seq.md
Name: data_mem_seq

Overview:
Parametrised, registered-output data memory with a multi-cycle power-on initialisation sequencer and a valid/ready request interface.
- Sits between the ALU and the register-file write-back port.
- Returns either memory read data or the ALU result, selected per request by MemToReg.
- Replaces single-cycle combinational-read memory; adds init sweep, stall handshake, range checking and 1-cycle read latency.

Parameters:
DW, 8, data width in bits
AW, 8, address width in bits
DEPTH, 256, number of words; DEPTH <= 2**AW
INIT_COUNT, 30, words 0..INIT_COUNT-1 loaded by the init sweep; 1 <= INIT_COUNT <= DEPTH
INIT_EVEN, 8'h55, init value for even addresses (DW bits)
INIT_ODD, 8'h05, init value for odd addresses (DW bits)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  1  request present this cycle
ReqReady  out  1  block accepts requests; low during init
WriteEn  in  1  1 = write request, 0 = read/pass request
MemToReg  in  1  read request: 1 = return Core[addr], 0 = return ALUdata
ALUdata  in  DW  ALU result for pass-through
DataAddress  in  AW  word address
DataIn  in  DW  write data
DataOut  out  DW  registered response data
RspValid  out  1  one-cycle pulse: DataOut valid
AddrErr  out  1  one-cycle pulse: accepted request had DataAddress >= DEPTH
InitDone  out  1  high once init sweep has completed

Behaviour:
- Reset is synchronous, active-high, clock Clk.
- Reset values: state=INIT, init counter=0, ReqReady=0, InitDone=0, RspValid=0, AddrErr=0, DataOut=0.
- Array contents are not cleared by reset beyond the init range.
- FSM states: INIT, RUN.
- INIT, per cycle:
  - write Core[cnt] = cnt[0] ? INIT_ODD : INIT_EVEN; cnt++.
  - When cnt == INIT_COUNT-1 is written, next state is RUN.
  - Sweep therefore takes exactly INIT_COUNT cycles after Reset deasserts.
- INIT: ReqReady=0; requests are ignored (no write, no response).
- RUN: ReqReady=1, InitDone=1; accept = ReqValid & ReqReady.
- Accepted write (WriteEn=1, addr < DEPTH): Core[addr] <= DataIn at that edge. No RspValid.
- Accepted read (WriteEn=0): next cycle RspValid=1 and DataOut = MemToReg ? Core[addr] : ALUdata. Latency is exactly 1 cycle.
- Back-to-back:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Reads issue every cycle at full throughput.
- Out-of-range (addr >= DEPTH), accepted:
  - Write is dropped; AddrErr pulses next cycle.
  - Read with MemToReg=1: DataOut=0, RspValid=1, AddrErr=1 next cycle.
  - Read with MemToReg=0: returns ALUdata normally, no error.
- DataOut holds its last value when RspValid=0.
- Reset asserted mid-operation (INIT or RUN):
  - Response pipeline is cleared the same edge; no RspValid on the following cycle.
  - FSM restarts INIT and cnt=0; init range is rewritten.
  - A write presented in the Reset cycle is discarded.
- Reset held for several cycles: INIT starts on the first cycle after Reset deasserts.

Decomposition:
- Package data_mem_pkg:
  - state enum {INIT, RUN}
  - default DW/AW constants
  - init pattern function init_word(addr) returning INIT_EVEN/INIT_ODD
- One sub-module: mem_array_1p (DEPTH x DW, one synchronous write port, one asynchronous read port).
- The top holds the FSM, init counter, address check and the response register.

Test Plan:
- Release Reset at cycle 0 with defaults -> ReqReady=0 for cycles 1..30, InitDone=1 and ReqReady=1 from cycle 31; read addr 0 -> 8'h55, addr 1 -> 8'h05, addr 29 -> 8'h05.
- During INIT, drive ReqValid=1, WriteEn=1, addr 3, DataIn 8'hFF -> no write; after InitDone, read addr 3 -> 8'h05, no RspValid during INIT.
- RUN: write 8'hA3 to addr 40, next cycle read addr 40 MemToReg=1 -> RspValid next cycle, DataOut=8'hA3; consecutive reads of addrs 0,1,40 -> 55, 05, A3 on three consecutive cycles.
- Read with MemToReg=0, ALUdata=8'h7E, addr 5 -> DataOut=8'h7E one cycle later, AddrErr=0.
- DEPTH=200: write 8'h11 to addr 250 -> AddrErr pulse, no write; read addr 250 MemToReg=1 -> DataOut=0, AddrErr=1.
- Write 8'h00 to addr 2, then pulse Reset during a pending read -> no RspValid next cycle; after re-init, addr 2 reads 8'h55 and addr 40 (outside init range) still reads 8'hA3.
